// File: rtl/hazard_dest_pipe.sv
// Destination/write-enable/opcode pipeline (EX, MEM, WB) with bubble insertion,
// stall counter and stuck-stall watchdog. Optional HAZ_R0_SUPPRESS_EN drops writes to R0.
//
// state       | meaning
// WD_IDLE     | stall low on the last edge; consecutive-stall counter is zero
// WD_STALLING | stall held; counter tracks consecutive stall edges (sat. at MAX_STALL+1)
module hazard_dest_pipe #(
    parameter int              REG_W     = 4,
    parameter int              OP_W      = 6,
    parameter logic [OP_W-1:0] BUBBLE_OP = 6'h3F,
    parameter int              CNT_W     = 16,
    parameter int              MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rw,
    input  logic [OP_W-1:0]  id_op,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [REG_W-1:0] rd2,
    output logic [REG_W-1:0] rd3,
    output logic [REG_W-1:0] rd4,
    output logic             rw2,
    output logic             rw3,
    output logic             rw4,
    output logic [OP_W-1:0]  ex_op,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);

    localparam int WD_W = $clog2(MAX_STALL + 2);
    localparam logic [WD_W-1:0] WD_SAT = WD_W'(MAX_STALL + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

    typedef enum logic {WD_IDLE, WD_STALLING} wd_state_e;

    logic [REG_W-1:0] rd2_q, rd3_q, rd4_q, rd2_d;
    logic             rw2_q, rw3_q, rw4_q, rw2_d;
    logic             v2_q, v3_q, v4_q, v2_d;
    logic [OP_W-1:0]  op2_q, op2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    wd_state_e        wd_state_q, wd_state_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             err_q, err_d;
    logic             rw_in;

    // Invalid ID slots become full bubbles so a stale opcode can never look like a load.
    always_comb begin
        rw_in = id_rw;
`ifdef HAZ_R0_SUPPRESS_EN
        if (id_rd == '0) rw_in = 1'b0;
`endif
        rd2_d = id_rd;
        rw2_d = rw_in & id_valid;
        v2_d  = id_valid;
        op2_d = id_op;
        if (stall || flush || !id_valid) begin
            rd2_d = '0;
            rw2_d = 1'b0;
            v2_d  = 1'b0;
            op2_d = BUBBLE_OP;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_comb begin
        wd_state_d = wd_state_q;
        wd_cnt_d   = wd_cnt_q;
        err_d      = err_q;
        case (wd_state_q)
            WD_IDLE: begin
                if (stall) begin
                    wd_state_d = WD_STALLING;
                    wd_cnt_d   = WD_W'(1);
                end
            end
            WD_STALLING: begin
                if (stall) begin
                    if (wd_cnt_q != WD_SAT) wd_cnt_d = wd_cnt_q + 1'b1;
                end else begin
                    wd_state_d = WD_IDLE;
                    wd_cnt_d   = '0;
                end
            end
            default: begin
                wd_state_d = WD_IDLE;
                wd_cnt_d   = '0;
            end
        endcase
        if (stall && (wd_cnt_d > WD_MAX)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd2_q       <= '0;
            rd3_q       <= '0;
            rd4_q       <= '0;
            rw2_q       <= 1'b0;
            rw3_q       <= 1'b0;
            rw4_q       <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            v4_q        <= 1'b0;
            op2_q       <= BUBBLE_OP;
            stall_cnt_q <= '0;
            wd_state_q  <= WD_IDLE;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            rd4_q       <= rd3_q;
            rw4_q       <= rw3_q;
            v4_q        <= v3_q;
            rd3_q       <= rd2_q;
            rw3_q       <= rw2_q;
            v3_q        <= v2_q;
            rd2_q       <= rd2_d;
            rw2_q       <= rw2_d;
            v2_q        <= v2_d;
            op2_q       <= op2_d;
            stall_cnt_q <= stall_cnt_d;
            wd_state_q  <= wd_state_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
        end
    end

    assign rd2       = rd2_q;
    assign rd3       = rd3_q;
    assign rd4       = rd4_q;
    assign rw2       = rw2_q & v2_q;
    assign rw3       = rw3_q & v3_q;
    assign rw4       = rw4_q & v4_q;
    assign ex_op     = op2_q;
    assign stall_cnt = stall_cnt_q;
    assign stall_err = err_q;

endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Self-checking bench for hazard_dest_pipe: vector table with a stage scoreboard,
// plus watchdog, reset-override and counter-saturation sequences.
module tb_hazard_dest_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] id_rd;
    logic       id_rw;
    logic [5:0] id_op;
    logic       id_valid;
    logic       stall;
    logic       flush;
    logic [3:0] rd2, rd3, rd4;
    logic       rw2, rw3, rw4;
    logic [5:0] ex_op;
    logic [15:0] stall_cnt;
    logic       stall_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] rd;
        logic       rw;
        logic [5:0] op;
    } slot_t;

    typedef struct {
        logic [3:0]  rd;
        logic        rw;
        logic [5:0]  op;
        logic        valid;
        logic        stall;
        logic        flush;
        logic [3:0]  exp_rd;
        logic        exp_rw;
        logic [5:0]  exp_op;
        logic [15:0] exp_cnt;
    } vec_t;

`ifdef HAZ_R0_SUPPRESS_EN
    localparam logic R0_RW = 1'b0;
`else
    localparam logic R0_RW = 1'b1;
`endif

    localparam int NV = 10;
    vec_t  vecs [NV];
    slot_t sb[$];

    hazard_dest_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .id_rd     (id_rd),
        .id_rw     (id_rw),
        .id_op     (id_op),
        .id_valid  (id_valid),
        .stall     (stall),
        .flush     (flush),
        .rd2       (rd2),
        .rd3       (rd3),
        .rd4       (rd4),
        .rw2       (rw2),
        .rw3       (rw3),
        .rw4       (rw4),
        .ex_op     (ex_op),
        .stall_cnt (stall_cnt),
        .stall_err (stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " rd2"}, 32'(rd2), 32'h0);
        chk({tag, " rd3"}, 32'(rd3), 32'h0);
        chk({tag, " rd4"}, 32'(rd4), 32'h0);
        chk({tag, " rw234"}, 32'({rw2, rw3, rw4}), 32'h0);
        chk({tag, " ex_op"}, 32'(ex_op), 32'h3F);
        chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'h0);
        chk({tag, " stall_err"}, 32'(stall_err), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        id_valid = 1'b0;
        tick();
        chk_reset_state("reset");
        reset = 1'b0;
        sb.delete();
        for (int k = 0; k < 3; k++) sb.push_back('{rd: 4'h0, rw: 1'b0, op: 6'h3F});
    endtask

    initial begin
        //           rd    rw    op     vld   stl   fl    erd   erw    eop    ecnt
        vecs[0] = '{4'd3,  1'b1, 6'h01, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1,  6'h01, 16'd0};
        vecs[1] = '{4'd5,  1'b1, 6'h02, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1,  6'h02, 16'd0};
        vecs[2] = '{4'd7,  1'b0, 6'h03, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0,  6'h03, 16'd0};
        vecs[3] = '{4'd4,  1'b1, 6'h06, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1,  6'h06, 16'd0};
        vecs[4] = '{4'd9,  1'b1, 6'h0A, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0,  6'h3F, 16'd1};
        vecs[5] = '{4'd9,  1'b1, 6'h0A, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1,  6'h0A, 16'd1};
        vecs[6] = '{4'd2,  1'b1, 6'h05, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0,  6'h3F, 16'd1};
        vecs[7] = '{4'd11, 1'b1, 6'h07, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,  6'h3F, 16'd1};
        vecs[8] = '{4'd0,  1'b1, 6'h04, 1'b1, 1'b0, 1'b0, 4'd0, R0_RW, 6'h04, 16'd1};
        vecs[9] = '{4'd6,  1'b1, 6'h08, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0,  6'h3F, 16'd2};

        id_rd = '0; id_rw = 1'b0; id_op = '0;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            id_rd    = vecs[i].rd;
            id_rw    = vecs[i].rw;
            id_op    = vecs[i].op;
            id_valid = vecs[i].valid;
            stall    = vecs[i].stall;
            flush    = vecs[i].flush;
            sb.push_back('{rd: vecs[i].exp_rd, rw: vecs[i].exp_rw, op: vecs[i].exp_op});
            void'(sb.pop_front());
            tick();
            chk($sformatf("v%0d rd2", i), 32'(rd2), 32'(sb[2].rd));
            chk($sformatf("v%0d rw2", i), 32'(rw2), 32'(sb[2].rw));
            chk($sformatf("v%0d ex_op", i), 32'(ex_op), 32'(sb[2].op));
            chk($sformatf("v%0d rd3", i), 32'(rd3), 32'(sb[1].rd));
            chk($sformatf("v%0d rw3", i), 32'(rw3), 32'(sb[1].rw));
            chk($sformatf("v%0d rd4", i), 32'(rd4), 32'(sb[0].rd));
            chk($sformatf("v%0d rw4", i), 32'(rw4), 32'(sb[0].rw));
            chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d stall_err", i), 32'(stall_err), 32'h0);
        end

        // Watchdog: 5 consecutive stalls trips the sticky error on the 5th edge.
        do_reset();
        id_valid = 1'b1; id_rd = 4'd8; id_rw = 1'b1; id_op = 6'h06;
        stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("wd edge%0d err", k), 32'(stall_err), (k >= 5) ? 32'h1 : 32'h0);
        end
        chk("wd stall_cnt", 32'(stall_cnt), 32'd5);
        stall = 1'b0;
        tick();
        chk("wd err sticky", 32'(stall_err), 32'h1);
        chk("wd release rd2", 32'(rd2), 32'd8);
        stall = 1'b1;
        tick();
        tick();
        chk("wd err after restall", 32'(stall_err), 32'h1);
        chk("wd cnt after restall", 32'(stall_cnt), 32'd7);

        // Reset asserted mid-stall with flush also high must win.
        reset = 1'b1;
        flush = 1'b1;
        tick();
        chk_reset_state("midstall reset");
        reset = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        tick();
        chk("post reset err", 32'(stall_err), 32'h0);

        // Four stalls is within budget.
        do_reset();
        stall = 1'b1;
        repeat (4) tick();
        stall = 1'b0;
        tick();
        chk("wd 4 stalls no err", 32'(stall_err), 32'h0);
        chk("wd 4 stalls cnt", 32'(stall_cnt), 32'd4);

        // Saturation: run the counter up to FFFE, then past the top.
        do_reset();
        stall = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat preload", 32'(stall_cnt), 32'hFFFE);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("sat edge%0d", k), 32'(stall_cnt), 32'hFFFF);
        end
        stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
